// File: rtl/imem_resp.sv
// Loadable instruction memory: a loader streams a program in, then the block
// serves one registered fetch per cycle from the processor PC.
module imem_resp #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ip_instr_addr,
  output logic [31:0] op_instr,
  output logic        op_instr_valid,
  output logic        op_fetch_fault,
  input  logic        ip_load_valid,
  input  logic [31:0] ip_load_data,
  input  logic        ip_load_last,
  output logic        op_load_overflow,
  output logic        op_running,
  output logic [31:0] op_fetch_count
);

  localparam int           AW      = $clog2(DEPTH);
  localparam logic [AW:0]  PTR_MAX = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t         state_q, state_d;
  logic [AW:0]    ptr_q, ptr_d;
  logic           ovf_q, ovf_d;
  logic           valid_q, valid_d;
  logic           fault_q, fault_d;
  logic [31:0]    count_q, count_d;

  logic [31:0]    mem [DEPTH];
  logic [31:0]    rd_data_q;
  logic           wr_en;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;
  logic           addr_ok;

  assign rd_idx  = ip_instr_addr[AW+1:2];
  assign wr_idx  = ptr_q[AW-1:0];
  assign addr_ok = (ip_instr_addr[1:0] == 2'b00) && ((ip_instr_addr >> (AW + 2)) == 32'd0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    fault_d = 1'b0;
    count_d = count_q;
    wr_en   = 1'b0;
    case (state_q)
      // IDLE and LOAD behave identically: ptr is always 0 while IDLE.
      IDLE, LOAD: begin
        if (ip_load_valid) begin
          if (ptr_q == PTR_MAX) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
          end
          state_d = ip_load_last ? RUN : LOAD;
        end
      end
      RUN: begin
        valid_d = addr_ok;
        fault_d = ~addr_ok;
        if (addr_ok) count_d = count_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // Array kept out of reset so it maps onto block RAM and survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= ip_load_data;
    rd_data_q <= mem[rd_idx];
  end

  assign op_instr         = valid_q ? rd_data_q : NOP_WORD;
  assign op_instr_valid   = valid_q;
  assign op_fetch_fault   = fault_q;
  assign op_load_overflow = ovf_q;
  assign op_running       = (state_q == RUN);
  assign op_fetch_count   = count_q;

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: a reference memory model feeds a scoreboard
// of expected fetch responses, checked one cycle after each address.
module tb_imem_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, ld;
  logic        lv, ll;
  logic [31:0] instr, cnt;
  logic        vld, flt, ovf, run;
  logic [31:0] addr4, ld4;
  logic        lv4, ll4;
  logic [31:0] instr4, cnt4;
  logic        vld4, flt4, ovf4, run4;

  always #5 clk = ~clk;

  imem_resp #(.DEPTH(256)) dut (
    .clk(clk), .rst(rst), .ip_instr_addr(addr), .op_instr(instr),
    .op_instr_valid(vld), .op_fetch_fault(flt), .ip_load_valid(lv),
    .ip_load_data(ld), .ip_load_last(ll), .op_load_overflow(ovf),
    .op_running(run), .op_fetch_count(cnt)
  );

  imem_resp #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .ip_instr_addr(addr4), .op_instr(instr4),
    .op_instr_valid(vld4), .op_fetch_fault(flt4), .ip_load_valid(lv4),
    .ip_load_data(ld4), .ip_load_last(ll4), .op_load_overflow(ovf4),
    .op_running(run4), .op_fetch_count(cnt4)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic [31:0] count;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl  [256];
  logic [31:0] mdl4 [4];
  int          ptr, ptr4;
  logic        movf4;
  logic [31:0] mcnt, mcnt4;
  int          total  = 0;
  int          passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic load(input bit sel, input logic [31:0] data, input logic last);
    @(negedge clk);
    if (sel) begin
      lv4 = 1'b1; ld4 = data; ll4 = last;
      if (ptr4 < 4) begin mdl4[ptr4] = data; ptr4++; end
      else movf4 = 1'b1;
    end else begin
      lv = 1'b1; ld = data; ll = last;
      if (ptr < 256) begin mdl[ptr] = data; ptr++; end
    end
    @(posedge clk); #1;
    lv = 1'b0; ll = 1'b0; lv4 = 1'b0; ll4 = 1'b0;
    $display("load sel=%0d data=%h last=%0d", sel, data, last);
  endtask

  task automatic fetch(input bit sel, input logic [31:0] a, input string tag);
    exp_t e;
    logic ok;
    logic [7:0] idx;
    idx = a[9:2];
    @(negedge clk);
    if (sel) addr4 = a; else addr = a;
    ok = (a[1:0] == 2'b00) && (a < (sel ? 32'd16 : 32'd1024));
    e.valid = ok;
    e.fault = ~ok;
    if (sel) begin
      e.instr = ok ? mdl4[idx[1:0]] : NOP;
      if (ok) mcnt4 = mcnt4 + 32'd1;
      e.count = mcnt4;
    end else begin
      e.instr = ok ? mdl[idx] : NOP;
      if (ok) mcnt = mcnt + 32'd1;
      e.count = mcnt;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, "_instr"}, sel ? instr4 : instr, e.instr);
    chk({tag, "_valid"}, sel ? vld4 : vld, 32'(e.valid));
    chk({tag, "_fault"}, sel ? flt4 : flt, 32'(e.fault));
    chk({tag, "_count"}, sel ? cnt4 : cnt, e.count);
    $display("fetch sel=%0d addr=%h instr=%h valid=%0d fault=%0d count=%h",
             sel, a, sel ? instr4 : instr, sel ? vld4 : vld, sel ? flt4 : flt, sel ? cnt4 : cnt);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_valid"}, 32'(vld), 32'd0);
    chk({tag, "_fault"}, 32'(flt), 32'd0);
    chk({tag, "_ovf"},   32'(ovf), 32'd0);
    chk({tag, "_run"},   32'(run), 32'd0);
    chk({tag, "_count"}, cnt, 32'd0);
  endtask

  task automatic rst_pulse(input string tag);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_reset(tag);
    $display("reset asserted asynchronously (%s)", tag);
    @(negedge clk);
    rst = 1'b1;
    ptr  = 0;
    mcnt = 32'd0;
  endtask

  initial begin
    rst = 1'b0; addr = '0; ld = '0; lv = 1'b0; ll = 1'b0;
    addr4 = '0; ld4 = '0; lv4 = 1'b0; ll4 = 1'b0;
    ptr = 0; ptr4 = 0; movf4 = 1'b0; mcnt = '0; mcnt4 = '0;
    #12;
    chk_reset("por");
    chk("por_run4", 32'(run4), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Program load and in-order fetch
    load(1'b0, 32'h0050_0093, 1'b0);
    load(1'b0, 32'h00A0_0113, 1'b0);
    load(1'b0, 32'h0020_81B3, 1'b0);
    chk("load_run", 32'(run), 32'd0);
    chk("load_nop", instr, NOP);
    load(1'b0, 32'h0000_0013, 1'b1);
    chk("enter_run", 32'(run), 32'd1);
    fetch(1'b0, 32'd0,  "f0");
    fetch(1'b0, 32'd4,  "f4");
    fetch(1'b0, 32'd8,  "f8");
    fetch(1'b0, 32'd12, "f12");
    fetch(1'b0, 32'h6,  "misalign");
    fetch(1'b0, 32'd1024, "range");
    fetch(1'b0, 32'd0,  "rep_a");
    fetch(1'b0, 32'd0,  "rep_b");

    // Loader activity while running must not write memory
    lv = 1'b1; ld = 32'hFFFF_FFFF; ll = 1'b1;
    fetch(1'b0, 32'd0, "run_ld_a");
    lv = 1'b0; ll = 1'b0;
    fetch(1'b0, 32'd0, "run_ld_b");
    chk("still_run", 32'(run), 32'd1);

    // Fetch counter wrap
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    mcnt = 32'hFFFF_FFFE;
    fetch(1'b0, 32'd4, "wrap_a");
    fetch(1'b0, 32'd8, "wrap_b");

    // Reset mid-RUN, stray last, reset mid-LOAD, then reload
    rst_pulse("rst_run");
    @(negedge clk); ll = 1'b1;
    @(posedge clk); #1;
    chk("last_no_valid", 32'(run), 32'd0);
    ll = 1'b0;
    load(1'b0, 32'hAAAA_0000, 1'b0);
    load(1'b0, 32'hBBBB_1111, 1'b0);
    rst_pulse("rst_load");
    load(1'b0, 32'hDEAD_BEEF, 1'b1);
    chk("single_run", 32'(run), 32'd1);
    fetch(1'b0, 32'd0, "reload0");
    fetch(1'b0, 32'd4, "keep4");
    fetch(1'b0, 32'd8, "keep8");

    // DEPTH=4 overflow
    load(1'b1, 32'h1000_0001, 1'b0);
    load(1'b1, 32'h1000_0002, 1'b0);
    load(1'b1, 32'h1000_0003, 1'b0);
    load(1'b1, 32'h1000_0004, 1'b0);
    chk("ovf_before", 32'(ovf4), 32'(movf4));
    load(1'b1, 32'h1000_0005, 1'b1);
    chk("ovf_after", 32'(ovf4), 32'(movf4));
    chk("ovf_run", 32'(run4), 32'd1);
    fetch(1'b1, 32'd12, "d4_12");
    fetch(1'b1, 32'd16, "d4_16");
    fetch(1'b1, 32'd0,  "d4_0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
